// File: rtl/rainbow_breath_ctrl.sv
// Rainbow breathing-light controller: shared rise/fall/off ramp spread over CH PWM outputs,
// with debounced speed/mode keys. Define RAINBOW_GAMMA_EN for a squared (gamma) duty ramp.
module rainbow_breath_ctrl #(
    parameter int CH       = 3,
    parameter int PWM_W    = 8,
    parameter int BASE_DIV = 64,
    parameter int DIV_W    = 16,
    parameter int DEB_CYC  = 50000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          key_up_i,
    input  logic          key_dn_i,
    input  logic          key_mode_i,
    output logic [CH-1:0] led_o,
    output logic [2:0]    spd_o,
    output logic [1:0]    mode_o
);
    localparam int DEB_W = $clog2(DEB_CYC);
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH - 1);
    localparam logic [PWM_W-1:0] PWM_MAX  = '1;
    localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(BASE_DIV);

    typedef enum logic {KEY_IDLE, KEY_HELD} keyState_e;

    logic [2:0]       keyRaw;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       pulse_q, pulse_d;
    keyState_e        keyState_q [3];
    keyState_e        keyState_d [3];
    logic [DEB_W-1:0] debCnt_q [3];
    logic [DEB_W-1:0] debCnt_d [3];

    logic [2:0]       spd_q, spd_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] presc_q, presc_d, prescTerm;
    logic [PWM_W-1:0] lvl_q, lvl_d;
    logic [1:0]       rot_q, rot_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [PWM_W-1:0] pc_q;
    logic [PWM_W-1:0] duty_q [CH];
    logic [PWM_W-1:0] duty_d [CH];
    logic [CH-1:0]    led_q, led_d;
    logic             spdInc, spdDec, spdChg, modeChg;

    assign keyRaw = {key_mode_i, key_dn_i, key_up_i};

    function automatic logic [PWM_W-1:0] shapeDuty(input logic [1:0] ph, input logic [PWM_W-1:0] lvl);
        logic [PWM_W-1:0] base;
`ifdef RAINBOW_GAMMA_EN
        logic [2*PWM_W-1:0] sq;
`endif
        case (ph)
            2'd0:    base = lvl;
            2'd1:    base = PWM_MAX - lvl;
            default: base = '0;
        endcase
`ifdef RAINBOW_GAMMA_EN
        sq = {{PWM_W{1'b0}}, base} * {{PWM_W{1'b0}}, base};
        return sq[2*PWM_W-1:PWM_W];
`else
        return base;
`endif
    endfunction

    function automatic logic [PWM_W-1:0] targetDuty(input int idx, input logic [1:0] md,
                                                    input logic [1:0] rot, input logic [SEL_W-1:0] sel,
                                                    input logic [PWM_W-1:0] lvl);
        logic [1:0] ph;
        logic       lit;
        ph  = rot;
        lit = 1'b1;
        case (md)
            2'd0:    ph  = 2'(((idx % 3) + int'(rot)) % 3);
            2'd1:    ph  = rot;
            2'd2:    lit = (sel == SEL_W'(idx));
            default: lit = 1'b0;
        endcase
        return lit ? shapeDuty(ph, lvl) : '0;
    endfunction

    // Each key waits for DEB_CYC stable-low samples before its single pulse, then for DEB_CYC highs to re-arm.
    always_comb begin
        pulse_d = '0;
        for (int k = 0; k < 3; k++) begin
            keyState_d[k] = keyState_q[k];
            debCnt_d[k]   = '0;
            case (keyState_q[k])
                KEY_IDLE: begin
                    if (!sync2_q[k]) begin
                        if (debCnt_q[k] == DEB_LAST) begin
                            pulse_d[k]    = 1'b1;
                            keyState_d[k] = KEY_HELD;
                        end else begin
                            debCnt_d[k] = debCnt_q[k] + 1'b1;
                        end
                    end
                end
                KEY_HELD: begin
                    if (sync2_q[k]) begin
                        if (debCnt_q[k] == DEB_LAST) begin
                            keyState_d[k] = KEY_IDLE;
                        end else begin
                            debCnt_d[k] = debCnt_q[k] + 1'b1;
                        end
                    end
                end
                default: keyState_d[k] = KEY_IDLE;
            endcase
        end
    end

    assign spdInc    = pulse_q[0] && !pulse_q[1] && (spd_q != 3'd7);
    assign spdDec    = pulse_q[1] && !pulse_q[0] && (spd_q != 3'd0);
    assign spdChg    = spdInc || spdDec;
    assign modeChg   = pulse_q[2];
    assign prescTerm = (DIV_BASE << (3'd7 - spd_q)) - 1'b1;

    // A mode change restarts the whole ramp; a speed change only restarts the current step.
    always_comb begin
        spd_d   = spd_q;
        mode_d  = mode_q;
        presc_d = presc_q + 1'b1;
        lvl_d   = lvl_q;
        rot_d   = rot_q;
        sel_d   = sel_q;
        if (spdInc) begin
            spd_d = spd_q + 3'd1;
        end else if (spdDec) begin
            spd_d = spd_q - 3'd1;
        end
        if (modeChg) begin
            mode_d  = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
            presc_d = '0;
            lvl_d   = '0;
            rot_d   = '0;
            sel_d   = '0;
        end else if (spdChg) begin
            presc_d = '0;
        end else if (presc_q == prescTerm) begin
            presc_d = '0;
            lvl_d   = lvl_q + 1'b1;
            if (lvl_q == PWM_MAX) begin
                rot_d = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
                sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            end
        end
    end

    // Duties are only reloaded on the last PWM count so a period never shows a mixed width.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < CH; i++) begin
            duty_d[i] = duty_q[i];
            led_d[i]  = (pc_q < duty_q[i]);
            if (pc_q == PWM_MAX) begin
                duty_d[i] = targetDuty(i, mode_q, rot_q, sel_q, lvl_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            pulse_q <= '0;
            for (int k = 0; k < 3; k++) begin
                keyState_q[k] <= KEY_IDLE;
                debCnt_q[k]   <= '0;
            end
            spd_q   <= 3'd4;
            mode_q  <= 2'd0;
            presc_q <= '0;
            lvl_q   <= '0;
            rot_q   <= '0;
            sel_q   <= '0;
            pc_q    <= '0;
            for (int i = 0; i < CH; i++) begin
                duty_q[i] <= '0;
            end
            led_q   <= '0;
        end else begin
            sync1_q <= keyRaw;
            sync2_q <= sync1_q;
            pulse_q <= pulse_d;
            for (int k = 0; k < 3; k++) begin
                keyState_q[k] <= keyState_d[k];
                debCnt_q[k]   <= debCnt_d[k];
            end
            spd_q   <= spd_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            lvl_q   <= lvl_d;
            rot_q   <= rot_d;
            sel_q   <= sel_d;
            pc_q    <= pc_q + 1'b1;
            for (int i = 0; i < CH; i++) begin
                duty_q[i] <= duty_d[i];
            end
            led_q   <= led_d;
        end
    end

    assign led_o  = led_q;
    assign spd_o  = spd_q;
    assign mode_o = mode_q;

endmodule

// File: tb/tb_rainbow_breath_ctrl.sv
// Scoreboard bench for rainbow_breath_ctrl: a behavioural model predicts LED/SPD/MODE each
// cycle into a queue, a negedge monitor compares; directed key sequences add fixed expectations.
module tb_rainbow_breath_ctrl;
    localparam int CH       = 3;
    localparam int PWM_W    = 4;
    localparam int BASE_DIV = 2;
    localparam int DIV_W    = 16;
    localparam int DEB_CYC  = 4;
    localparam int PMAX     = (1 << PWM_W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          keyUp, keyDn, keyMode;
    logic [CH-1:0] led;
    logic [2:0]    spd;
    logic [1:0]    mode;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCount  = 0;

    typedef struct packed {
        logic [CH-1:0] led;
        logic [2:0]    spd;
        logic [1:0]    mode;
    } expect_t;

    expect_t expQ[$];

    rainbow_breath_ctrl #(
        .CH(CH), .PWM_W(PWM_W), .BASE_DIV(BASE_DIV), .DIV_W(DIV_W), .DEB_CYC(DEB_CYC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .key_up_i(keyUp), .key_dn_i(keyDn), .key_mode_i(keyMode),
        .led_o(led), .spd_o(spd), .mode_o(mode)
    );

    always #5 clk = ~clk;

    // Reference model state: keys are indexed 0 up, 1 down, 2 mode.
    int            mSync1[3], mSync2[3], mHeld[3], mRun[3], mPulse[3];
    int            mSpd, mMode, mPresc, mLvl, mRot, mSel, mPc;
    int            mDuty[CH];
    logic [CH-1:0] mLed;

    function automatic int refDuty(input int ch, input int md, input int rot, input int sel, input int lvl);
        int ph;
        if (md == 0)      ph = (ch % 3 + rot) % 3;
        else if (md == 1) ph = rot;
        else              ph = (ch == sel) ? rot : 2;
        if (ph == 0) return lvl;
        if (ph == 1) return PMAX - lvl;
        return 0;
    endfunction

    always @(posedge clk) begin
        int      keysNow[3];
        int      spdNext, period;
        expect_t e;
        keysNow[0] = int'(keyUp);
        keysNow[1] = int'(keyDn);
        keysNow[2] = int'(keyMode);
        cycleCount++;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                mSync1[k] = 1; mSync2[k] = 1; mHeld[k] = 0; mRun[k] = 0; mPulse[k] = 0;
            end
            mSpd = 4; mMode = 0; mPresc = 0; mLvl = 0; mRot = 0; mSel = 0; mPc = 0;
            for (int i = 0; i < CH; i++) mDuty[i] = 0;
            mLed = '0;
        end else begin
            for (int i = 0; i < CH; i++) mLed[i] = (mPc < mDuty[i]);
            if (mPc == PMAX)
                for (int i = 0; i < CH; i++) mDuty[i] = refDuty(i, mMode, mRot, mSel, mLvl);
            mPc = (mPc + 1) % (PMAX + 1);

            spdNext = mSpd;
            if (mPulse[0] == 1 && mPulse[1] == 0) spdNext = (mSpd < 7) ? mSpd + 1 : 7;
            if (mPulse[1] == 1 && mPulse[0] == 0) spdNext = (mSpd > 0) ? mSpd - 1 : 0;
            period = BASE_DIV * (1 << (7 - mSpd));
            if (mPulse[2] == 1) begin
                mMode = (mMode + 1) % 3;
                mPresc = 0; mLvl = 0; mRot = 0; mSel = 0;
            end else if (spdNext != mSpd) begin
                mPresc = 0;
            end else if (mPresc == period - 1) begin
                mPresc = 0;
                mLvl++;
                if (mLvl > PMAX) begin
                    mLvl = 0;
                    mRot = (mRot + 1) % 3;
                    mSel = (mSel + 1) % CH;
                end
            end else begin
                mPresc++;
            end
            mSpd = spdNext;

            for (int k = 0; k < 3; k++) begin
                mPulse[k] = 0;
                if (mHeld[k] == 0) begin
                    if (mSync2[k] == 0) begin
                        mRun[k]++;
                        if (mRun[k] == DEB_CYC) begin mPulse[k] = 1; mHeld[k] = 1; mRun[k] = 0; end
                    end else mRun[k] = 0;
                end else begin
                    if (mSync2[k] == 1) begin
                        mRun[k]++;
                        if (mRun[k] == DEB_CYC) begin mHeld[k] = 0; mRun[k] = 0; end
                    end else mRun[k] = 0;
                end
                mSync2[k] = mSync1[k];
                mSync1[k] = keysNow[k];
            end
        end
        e.led  = mLed;
        e.spd  = 3'(mSpd);
        e.mode = 2'(mMode);
        expQ.push_back(e);
    end

    always @(negedge clk) begin
        expect_t e;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard: no expectation queued at cycle %0d", cycleCount);
        end else begin
            e = expQ.pop_front();
            if ({led, spd, mode} !== e) begin
                testsFailed++;
                $display("[TB] FAIL outputs cycle %0d: got led=%b spd=%0d mode=%0d, expected led=%b spd=%0d mode=%0d",
                         cycleCount, led, spd, mode, e.led, e.spd, e.mode);
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int want);
        testsRun++;
        if (got != want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic holdIdle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic u, input logic d, input logic m, input int lowCyc, input int highCyc);
        @(negedge clk);
        keyUp = ~u; keyDn = ~d; keyMode = ~m;
        holdIdle(lowCyc);
        keyUp = 1'b1; keyDn = 1'b1; keyMode = 1'b1;
        holdIdle(highCyc);
    endtask

    initial begin
        automatic int upExp[5] = '{5, 6, 7, 7, 7};
        automatic int dnExp[8] = '{6, 5, 4, 3, 2, 1, 0, 0};
        automatic int pick;
        automatic int ones;
        rst = 1'b1; keyUp = 1'b1; keyDn = 1'b1; keyMode = 1'b1;
        holdIdle(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset spd", int'(spd), 4);
        checkOutput("reset mode", int'(mode), 0);
        checkOutput("reset led", int'(led), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 10, 10);
            checkOutput($sformatf("up press %0d spd", i), int'(spd), upExp[i]);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 10, 10);
            checkOutput($sformatf("down press %0d spd", i), int'(spd), dnExp[i]);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 10, 10);
        checkOutput("single up spd", int'(spd), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 10, 10);
        checkOutput("up+down together spd", int'(spd), 1);

        applyStimulus(1'b0, 1'b0, 1'b1, 3, 10);
        checkOutput("mode glitch", int'(mode), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 20, 10);
        checkOutput("mode held press", int'(mode), 1);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 10, 10);
        checkOutput("speed to max", int'(spd), 7);
        applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
        checkOutput("mode step to single", int'(mode), 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
        checkOutput("mode wrap to rainbow", int'(mode), 0);
        holdIdle(400);
        applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
        checkOutput("mode sync", int'(mode), 1);
        holdIdle(150);
        applyStimulus(1'b0, 1'b0, 1'b1, 10, 10);
        checkOutput("mode single", int'(mode), 2);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ones = $countones(led);
            checkOutput("single mode one led", (ones <= 1) ? 1 : 0, 1);
        end

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-ramp reset spd", int'(spd), 4);
        checkOutput("mid-ramp reset mode", int'(mode), 0);
        checkOutput("mid-ramp reset led", int'(led), 0);
        rst = 1'b0;

        for (int n = 0; n < 80; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else if (pick < 3) begin
                holdIdle($urandom_range(20, 200));
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              $urandom_range(1, 12), $urandom_range(1, 14));
            end
        end

        holdIdle(4);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
